// File: rtl/sample_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sample_stream_pkg
// Brief    : Shared sample-stream types and system-level sizing constants.
// Revision : 1.0 - initial release
// ============================================================================
package sample_stream_pkg;

   localparam int SAMPLE_WIDTH  = 16;
   localparam int EPOCH_SAMPLES = 30;

   typedef logic [SAMPLE_WIDTH-1:0] sample_t;

endpackage : sample_stream_pkg
`default_nettype wire

// File: rtl/fifo_window_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_window_reader_if
// Brief    : FIFO read port plus downstream valid/ready stream of the reader.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_window_reader_if
   import sample_stream_pkg::*;
#(
   parameter int DATA_WIDTH = SAMPLE_WIDTH
);

   logic                  enable;
   logic                  fifo_rd_req;
   logic                  fifo_rd_valid;
   logic [DATA_WIDTH-1:0] fifo_rd_data;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic                  m_ready;
   logic                  protocol_err;

   modport master (
      input  enable,
      input  fifo_rd_valid,
      input  fifo_rd_data,
      input  m_ready,
      output fifo_rd_req,
      output m_valid,
      output m_data,
      output m_last,
      output protocol_err
   );

   modport slave (
      output enable,
      output fifo_rd_valid,
      output fifo_rd_data,
      output m_ready,
      input  fifo_rd_req,
      input  m_valid,
      input  m_data,
      input  m_last,
      input  protocol_err
   );

endinterface : fifo_window_reader_if
`default_nettype wire

// File: rtl/fifo_window_reader_buf.sv
`default_nettype none
// ============================================================================
// Module   : reader_buf
// Brief    : Small register-array ring buffer with write port, read head and
//            occupancy count for the FIFO window reader.
// Revision : 1.0 - initial release
// ============================================================================
module reader_buf
   import sample_stream_pkg::*;
#(
   parameter int DATA_WIDTH = SAMPLE_WIDTH,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          i_wr_en,
   input  logic [DATA_WIDTH-1:0]         i_wr_data,
   input  logic                          i_rd_en,
   output logic [$clog2(BUF_DEPTH):0]    o_count,
   output logic [DATA_WIDTH-1:0]         o_rd_data
);

   localparam int c_PTR_W = $clog2(BUF_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_CNT_W-1:0]    r_count;

   // Caller guarantees no write when full and no read when empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
            r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
         end
         if (i_rd_en) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({i_wr_en, i_rd_en})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

endmodule : reader_buf
`default_nettype wire

// File: rtl/fifo_window_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_window_reader
// Brief    : Credit-managed read-side controller for the sample FIFO; streams
//            samples downstream and flags the last sample of every window.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_window_reader
   import sample_stream_pkg::*;
#(
   parameter int DATA_WIDTH = SAMPLE_WIDTH,
   parameter int BUF_DEPTH  = 4,
   parameter int WINDOW_LEN = EPOCH_SAMPLES
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_window_reader_if.master bus
);

   localparam int c_PTR_W = $clog2(BUF_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_IDX_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(BUF_DEPTH);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WINDOW_LEN - 1);

   logic [c_CNT_W-1:0]    w_count;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_valid;
   logic                  w_req;
   logic                  w_wr;
   logic                  w_xfer;

   logic                  r_pending;
   logic                  r_after_reset;
   logic                  r_protocol_err;
   logic [c_IDX_W-1:0]    r_sample_idx;

   // An in-flight pop already owns a slot, so it is counted as a credit.
   assign w_valid = (w_count != '0);
   assign w_req   = bus.enable & ~reset
                  & ((w_count + c_CNT_W'(r_pending)) < c_DEPTH);
   assign w_wr    = bus.fifo_rd_valid & r_pending;
   assign w_xfer  = w_valid & bus.m_ready;

   reader_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_wr),
      .i_wr_data (bus.fifo_rd_data),
      .i_rd_en   (w_xfer),
      .o_count   (w_count),
      .o_rd_data (w_rd_data)
   );

   // A response landing right after reset belongs to a pre-reset request.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending      <= 1'b0;
         r_after_reset  <= 1'b1;
         r_protocol_err <= 1'b0;
         r_sample_idx   <= '0;
      end else begin
         r_pending     <= w_req;
         r_after_reset <= 1'b0;
         if (bus.fifo_rd_valid & ~r_pending & ~r_after_reset) begin
            r_protocol_err <= 1'b1;
         end
         if (w_xfer) begin
            if (r_sample_idx == c_IDX_LAST) begin
               r_sample_idx <= '0;
            end else begin
               r_sample_idx <= r_sample_idx + c_IDX_W'(1);
            end
         end
      end
   end

   assign bus.fifo_rd_req  = w_req;
   assign bus.m_valid      = w_valid;
   assign bus.m_data       = w_rd_data;
   assign bus.m_last       = w_valid & (r_sample_idx == c_IDX_LAST);
   assign bus.protocol_err = r_protocol_err;

endmodule : fifo_window_reader
`default_nettype wire

// File: tb/tb_fifo_window_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_window_reader
// Brief    : Self-checking bench; queue-based FIFO and buffer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_window_reader;

   localparam int c_DEPTH = 4;
   localparam int c_WIN   = 30;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        m_ready = 1'b0;
   logic        fifo_rd_valid = 1'b0;
   logic [15:0] fifo_rd_data = '0;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [15:0] fifo_q[$];
   logic [15:0] bq[$];
   logic [15:0] log_d[$];
   bit          log_l[$];
   int          log_c[$];
   bit          inflight  = 1'b0;
   bit          err_m     = 1'b0;
   bit          after_rst = 1'b1;
   bit          resp_v    = 1'b0;
   logic [15:0] resp_d    = '0;
   int          nxfer     = 0;

   always #5 clk = ~clk;

   fifo_window_reader_if bus0 ();
   fifo_window_reader_if bus1 ();

   assign bus0.enable        = enable;
   assign bus0.m_ready       = m_ready;
   assign bus0.fifo_rd_valid = fifo_rd_valid;
   assign bus0.fifo_rd_data  = fifo_rd_data;
   assign bus1.enable        = enable;
   assign bus1.m_ready       = m_ready;
   assign bus1.fifo_rd_valid = fifo_rd_valid;
   assign bus1.fifo_rd_data  = fifo_rd_data;

   fifo_window_reader #(.DATA_WIDTH(16), .BUF_DEPTH(c_DEPTH), .WINDOW_LEN(c_WIN)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0.master)
   );

   fifo_window_reader #(.DATA_WIDTH(16), .BUF_DEPTH(c_DEPTH), .WINDOW_LEN(1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.master)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // One clock cycle: drive at negedge, check against model, advance model.
   task automatic step(input bit en, input bit rdy, input bit rst, input bit inj);
      bit          exp_req, exp_valid, xfer, fv;
      logic [15:0] fd;
      reset   = rst;
      enable  = en;
      m_ready = rdy;
      fv = resp_v | inj;
      fd = inj ? 16'hDEAD : resp_d;
      fifo_rd_valid = fv;
      fifo_rd_data  = fd;
      #1;
      exp_req   = !rst && en && ((bq.size() + int'(inflight)) < c_DEPTH);
      exp_valid = (bq.size() != 0);
      check("fifo_rd_req",  bus0.fifo_rd_req, exp_req);
      check("req_w1",       bus1.fifo_rd_req, exp_req);
      check("m_valid",      bus0.m_valid, exp_valid);
      check("m_last",       bus0.m_last, exp_valid && ((nxfer % c_WIN) == c_WIN - 1));
      check("m_last_w1",    bus1.m_last, exp_valid);
      check("protocol_err", bus0.protocol_err, err_m);
      if (exp_valid) check("m_data", bus0.m_data, bq[0]);
      else if (after_rst) check("m_data_rst", bus0.m_data, 0);
      if (rst) begin
         bq.delete();
         inflight  = 0;
         err_m     = 0;
         after_rst = 1;
         resp_v    = 0;
         nxfer     = 0;
      end else begin
         xfer = exp_valid && rdy;
         if (xfer) begin
            log_d.push_back(bus0.m_data);
            log_l.push_back(bus0.m_last);
            log_c.push_back(cyc);
            void'(bq.pop_front());
            nxfer++;
         end
         if (fv) begin
            if (inflight) bq.push_back(fd);
            else if (!after_rst) err_m = 1;
         end
         after_rst = 0;
         inflight  = exp_req;
         resp_v    = 0;
         if (exp_req && fifo_q.size() > 0) begin
            resp_v = 1;
            resp_d = fifo_q.pop_front();
         end
      end
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_log();
      log_d.delete();
      log_l.delete();
      log_c.delete();
   endtask

   initial begin
      int start;
      repeat (3) @(posedge clk);
      @(negedge clk);
      step(0, 0, 1, 0);

      // Single sample
      fifo_q.push_back(16'h00A5);
      clear_log();
      for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
      check("single_count", log_d.size(), 1);
      if (log_d.size() == 1) begin
         check("single_data", log_d[0], 16'h00A5);
         check("single_last", log_l[0], 0);
      end

      // Streaming 0..63 from fresh reset
      step(0, 0, 1, 0);
      for (int i = 0; i < 64; i++) fifo_q.push_back(16'(i));
      clear_log();
      start = cyc;
      for (int i = 0; i < 72; i++) step(1, 1, 0, 0);
      check("stream_count", log_d.size(), 64);
      if (log_d.size() == 64) begin
         check("stream_latency", log_c[0] - start, 2);
         check("stream_rate", log_c[63] - log_c[0], 63);
         for (int i = 0; i < 64; i++) begin
            check("stream_data", log_d[i], i);
            check("stream_last", log_l[i], (i == 29 || i == 59));
         end
      end

      // Backpressure mid-stream
      step(0, 0, 1, 0);
      for (int i = 0; i < 64; i++) fifo_q.push_back(16'(100 + i));
      clear_log();
      for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
      check("bp_req_low", bus0.fifo_rd_req, 0);
      check("bp_full", bq.size(), c_DEPTH);
      for (int i = 0; i < 64; i++) step(1, 1, 0, 0);
      check("bp_count", log_d.size(), 64);
      for (int i = 0; i < log_d.size(); i++) check("bp_data", log_d[i], 100 + i);

      // Enable pause: request in flight when enable drops
      for (int i = 0; i < 8; i++) fifo_q.push_back(16'(300 + i));
      clear_log();
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      check("pause_delivered", log_d.size(), 1);
      for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
      check("pause_total", log_d.size(), 8);
      for (int i = 0; i < log_d.size(); i++) check("pause_data", log_d[i], 300 + i);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if (fifo_q.size() < 3 && $urandom_range(0, 3) != 0) fifo_q.push_back(16'($urandom));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, 0, 0);
      end

      // Protocol error
      fifo_q.delete();
      for (int i = 0; i < 20 && (bq.size() != 0 || inflight || resp_v); i++) step(0, 1, 0, 0);
      if (bq.size() != 0 || inflight || resp_v) check("drain_timeout", 1, 0);
      step(0, 1, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      check("err_sticky", bus0.protocol_err, 1);
      check("err_dropped", bus0.m_valid, 0);

      // Reset mid-stream with 3 entries buffered
      for (int i = 0; i < 40; i++) fifo_q.push_back(16'(500 + i));
      for (int i = 0; i < 10 && bq.size() != 3; i++) step(1, 0, 0, 0);
      check("pre_rst_fill", bq.size(), 3);
      step(1, 0, 1, 0);
      check("rst_valid", bus0.m_valid, 0);
      check("rst_err", bus0.protocol_err, 0);
      check("rst_last", bus0.m_last, 0);
      step(1, 1, 0, 1);
      check("rst_late_resp", bus0.protocol_err, 0);
      clear_log();
      for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
      if (log_l.size() > 0) check("rst_first_last", log_l[0], 0);
      else check("rst_first_xfer", 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_fifo_window_reader
`default_nettype wire
